// File: rtl/operand_hazard_ctrl.sv
// Decode-stage RAW hazard controller for the EX operand-B mux.
// A shift-register scoreboard tracks in-flight register writes from EX through WB.
// While a RAW hazard is pending, fetch/decode is stalled and bubbles are issued into EX.
// Optional feature: define HAZ_STALL_CNT_EN to add a saturating stall-cycle counter
// (CNT_W parameter and o_stall_cnt port).
module operand_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3
`ifdef HAZ_STALL_CNT_EN
  ,
  parameter int unsigned CNT_W  = 32
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_id_use_rs,
  input  logic              i_id_use_rt,
  input  logic              i_id_imm,
  input  logic              i_id_we,
  input  logic [REG_AW-1:0] i_id_wa,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_ex_valid,
  output logic              o_ex_mux_sel,
  output logic              o_ex_we,
  output logic [REG_AW-1:0] o_ex_wa
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

  // Scoreboard: entry 0 = EX, entry DEPTH-1 = WB.
  logic [DEPTH-1:0]  r_sb_v;
  logic [REG_AW-1:0] r_sb_wa [DEPTH];

  logic              r_ex_valid;
  logic              r_ex_mux_sel;
  logic              r_ex_we;
  logic [REG_AW-1:0] r_ex_wa;

  logic w_match_rs;
  logic w_match_rt;
  logic w_wa_nz;
  logic w_hazard;
  logic w_issue;

  // Compare both source registers against every valid in-flight write; r0 never matches.
  always_comb begin
    w_match_rs = 1'b0;
    w_match_rt = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_sb_v[i] && (r_sb_wa[i] == i_id_rs)) w_match_rs = 1'b1;
      if (r_sb_v[i] && (r_sb_wa[i] == i_id_rt)) w_match_rt = 1'b1;
    end
    if (i_id_rs == '0) w_match_rs = 1'b0;
    if (i_id_rt == '0) w_match_rt = 1'b0;
  end

  // Hazard / issue decision; the immediate form never reads rt through the mux.
  always_comb begin
    w_wa_nz  = |i_id_wa;
    w_hazard = i_id_valid &&
               ((i_id_use_rs && w_match_rs) || (i_id_use_rt && !i_id_imm && w_match_rt));
    // Flush wins over a hazard: the slot becomes a bubble rather than a stall.
    w_issue  = i_id_valid && !w_hazard && !i_flush;
    o_stall  = w_hazard && !i_flush && !i_rst;
  end

  // Scoreboard shift and ID/EX control registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sb_v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sb_wa[i] <= '0;
      end
      r_ex_valid   <= 1'b0;
      r_ex_mux_sel <= 1'b0;
      r_ex_we      <= 1'b0;
      r_ex_wa      <= '0;
    end else begin
      r_sb_v[0]  <= w_issue & i_id_we & w_wa_nz;
      r_sb_wa[0] <= w_issue ? i_id_wa : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sb_v[i]  <= r_sb_v[i-1];
        r_sb_wa[i] <= r_sb_wa[i-1];
      end
      r_ex_valid   <= w_issue;
      r_ex_mux_sel <= w_issue & i_id_imm;
      r_ex_we      <= w_issue & i_id_we & w_wa_nz;
      r_ex_wa      <= w_issue ? i_id_wa : '0;
    end
  end

  assign o_ex_valid   = r_ex_valid;
  assign o_ex_mux_sel = r_ex_mux_sel;
  assign o_ex_we      = r_ex_we;
  assign o_ex_wa      = r_ex_wa;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of stalled cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (o_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// Self-checking bench for operand_hazard_ctrl (DEPTH=3, REG_AW=5).
// Each scenario task builds a row table; expected EX contents are queued when a row is
// driven and popped/compared after the clock edge that registers them.
module tb_operand_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic       m;
    logic       we;
    logic [4:0] wa;
  } ex_t;

  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       imm;
    logic       we;
    logic [4:0] wa;
    logic       fl;
    logic       stall;
    ex_t        ex;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_imm;
  logic       id_we;
  logic [4:0] id_wa;
  logic       flush;
  logic       stall;
  logic       ex_valid;
  logic       ex_mux_sel;
  logic       ex_we;
  logic [4:0] ex_wa;
`ifdef HAZ_STALL_CNT_EN
  logic [1:0] stall_cnt;
`endif

  int  checks = 0;
  int  errors = 0;
  ex_t exp_q[$];

  always #5 clk = ~clk;

  operand_hazard_ctrl #(
    .REG_AW (5),
    .DEPTH  (3)
`ifdef HAZ_STALL_CNT_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_id_valid   (id_valid),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_use_rs  (id_use_rs),
    .i_id_use_rt  (id_use_rt),
    .i_id_imm     (id_imm),
    .i_id_we      (id_we),
    .i_id_wa      (id_wa),
    .i_flush      (flush),
    .o_stall      (stall),
    .o_ex_valid   (ex_valid),
    .o_ex_mux_sel (ex_mux_sel),
    .o_ex_we      (ex_we),
    .o_ex_wa      (ex_wa)
`ifdef HAZ_STALL_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  function automatic row_t mk(input logic r, input logic v, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urs, input logic urt,
                              input logic imm, input logic we, input logic [4:0] wa,
                              input logic fl, input logic st, input logic ev, input logic em,
                              input logic ewe, input logic [4:0] ewa);
    row_t x;
    x.rst = r; x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.imm = imm;
    x.we = we; x.wa = wa; x.fl = fl; x.stall = st;
    x.ex = '{v: ev, m: em, we: ewe, wa: ewa};
    return x;
  endfunction

  function automatic row_t idle_row();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic apply(input row_t x);
    rst = x.rst; id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs;
    id_use_rt = x.urt; id_imm = x.imm; id_we = x.we; id_wa = x.wa; flush = x.fl;
  endtask

  task automatic test_reset();
    row_t rows[$];
    ex_t  got;
    rows.push_back(mk(1, 1, 3, 3, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 3, 3, 1, 1, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    rows.push_back(idle_row());
    // Reset mid-operation must clear the in-flight write to r7.
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 7, 0, 0, 1, 0, 1, 7));
    rows.push_back(mk(1, 1, 7, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 7, 0, 1, 0, 0, 1, 8, 0, 0, 1, 0, 1, 8));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL reset_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL reset_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    ex_t  got;
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0, 1, 3));
    repeat (3) rows.push_back(mk(0, 1, 3, 0, 1, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 3, 0, 1, 0, 0, 1, 4, 0, 0, 1, 0, 1, 4));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL b2b_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL b2b_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask

  task automatic test_itype();
    row_t rows[$];
    ex_t  got;
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0, 1, 3));
    // Immediate form reading rt=r3 must not stall.
    rows.push_back(mk(0, 1, 1, 3, 1, 1, 1, 1, 3, 0, 0, 1, 1, 1, 3));
    // Register form reading rt=r3 stalls until the younger write drains.
    repeat (3) rows.push_back(mk(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL itype_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL itype_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask

  task automatic test_r0();
    row_t rows[$];
    ex_t  got;
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 9, 0, 0, 1, 0, 1, 9));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL r0_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL r0_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    ex_t  got;
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 6, 0, 0, 1, 0, 1, 6));
    // Flush during a hazard: no stall, bubble issued.
    rows.push_back(mk(0, 1, 6, 0, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0));
    // The r6 entry keeps draining: two more stall cycles, then issue.
    repeat (2) rows.push_back(mk(0, 1, 6, 0, 1, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 6, 0, 1, 0, 0, 1, 2, 0, 0, 1, 0, 1, 2));
    // Flush without a hazard kills the instruction.
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL flush_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL flush_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask

  task automatic test_multi_match();
    row_t rows[$];
    ex_t  got;
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0, 1, 3));
    rows.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0, 1, 3));
    repeat (3) rows.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL multi_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL multi_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask

`ifdef HAZ_STALL_CNT_EN
  task automatic test_stall_counter();
    row_t       rows[$];
    ex_t        got;
    int         n = 0;
    logic [1:0] exp_cnt;
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0, 1, 3));
    repeat (3) rows.push_back(mk(0, 1, 3, 0, 1, 0, 0, 1, 4, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(0, 1, 3, 0, 1, 0, 0, 1, 4, 0, 0, 1, 0, 1, 4));
    repeat (2) rows.push_back(mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) rows.push_back(idle_row());
    foreach (rows[i]) begin
      apply(rows[i]);
      exp_q.push_back(rows[i].ex);
      #1;
      checks++;
      if (stall !== rows[i].stall) begin
        errors++;
        $display("FAIL cnt_stall row %0d: got %b want %b", i, stall, rows[i].stall);
      end
      @(posedge clk); #1;
      if (rows[i].rst) n = 0;
      else if (rows[i].stall) n++;
      exp_cnt = (n > 3) ? 2'd3 : 2'(n);
      checks++;
      if (stall_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL cnt_value row %0d: got %0d want %0d", i, stall_cnt, exp_cnt);
      end
      got = exp_q.pop_front();
      checks++;
      if ({ex_valid, ex_mux_sel, ex_we, ex_wa} !== got) begin
        errors++;
        $display("FAIL cnt_ex row %0d: got %b want %b", i,
                 {ex_valid, ex_mux_sel, ex_we, ex_wa}, got);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(idle_row());
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_itype();
    test_r0();
    test_flush();
    test_multi_match();
`ifdef HAZ_STALL_CNT_EN
    test_stall_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
